multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/timer_pkg.sv | 12 +
 rtl/ms_tick_gen.sv | 28 ++
 rtl/multi_timer.sv | 88 ++++++++
 tb/tb_multi_timer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared channel state encoding for multi_timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  localparam int TIMER_MAX_CH = 16;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler, one tick per CLKS_PER_MS enabled cycles
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign tick      = enable && w_at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N_CH independent millisecond timers sharing one prescaler
module multi_timer
  import timer_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CLKS_PER_MS = 50000,
  parameter int MS_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_CH-1:0]          start,
  input  logic [N_CH-1:0]          stop,
  input  logic [N_CH-1:0]          periodic,
  input  logic [N_CH*MS_WIDTH-1:0] period_ms,
  output logic [N_CH-1:0]          expired,
  output logic [N_CH-1:0]          running,
  output logic [N_CH-1:0]          done,
  output logic [N_CH*MS_WIDTH-1:0] remaining_ms
);

  logic w_tick;

  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (w_tick)
  );

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ch_state_t           r_state;
    logic [MS_WIDTH-1:0] r_rem;
    logic                r_periodic;
    logic                r_expired;
    logic                r_running;
    logic                r_done;
    logic [MS_WIDTH-1:0] w_period;

    assign w_period = period_ms[gi*MS_WIDTH +: MS_WIDTH];

    // Priority: stop, then a valid start, then the shared tick while running.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state    <= ST_IDLE;
        r_rem      <= '0;
        r_periodic <= 1'b0;
        r_expired  <= 1'b0;
        r_running  <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        r_expired <= 1'b0;
        if (stop[gi]) begin
          r_state   <= ST_IDLE;
          r_rem     <= '0;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end else if (start[gi] && (w_period != '0)) begin
          r_state    <= ST_RUN;
          r_rem      <= w_period;
          r_periodic <= periodic[gi];
          r_running  <= 1'b1;
          r_done     <= 1'b0;
        end else if ((r_state == ST_RUN) && w_tick) begin
          if (r_rem > MS_WIDTH'(1)) begin
            r_rem <= r_rem - 1'b1;
          end else begin
            r_expired <= 1'b1;
            if (r_periodic && (w_period != '0)) begin
              r_rem <= w_period;
            end else begin
              r_state   <= ST_DONE;
              r_rem     <= '0;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
      end
    end

    assign expired[gi]                             = r_expired;
    assign running[gi]                             = r_running;
    assign done[gi]                                = r_done;
    assign remaining_ms[gi*MS_WIDTH +: MS_WIDTH]   = r_rem;
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed and random checks of multi_timer against a reference model
module tb_multi_timer;

  localparam int N_CH = 4;
  localparam int CPM  = 4;
  localparam int MSW  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [N_CH-1:0]     start;
  logic [N_CH-1:0]     stop;
  logic [N_CH-1:0]     periodic;
  logic [N_CH*MSW-1:0] period_ms;
  logic [N_CH-1:0]     expired;
  logic [N_CH-1:0]     running;
  logic [N_CH-1:0]     done;
  logic [N_CH*MSW-1:0] remaining_ms;

  always #5 clk = ~clk;

  multi_timer #(.N_CH(N_CH), .CLKS_PER_MS(CPM), .MS_WIDTH(MSW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .stop         (stop),
    .periodic     (periodic),
    .period_ms    (period_ms),
    .expired      (expired),
    .running      (running),
    .done         (done),
    .remaining_ms (remaining_ms)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: tick derived from the count of enabled cycles since reset.
  int en_cycles;
  bit m_tick;
  bit m_run  [N_CH];
  bit m_done [N_CH];
  bit m_exp  [N_CH];
  bit m_per  [N_CH];
  int m_rem  [N_CH];

  function automatic int per_of(input int ch);
    return int'(period_ms[ch*MSW +: MSW]);
  endfunction

  function automatic int rem_of(input int ch);
    return int'(remaining_ms[ch*MSW +: MSW]);
  endfunction

  task automatic set_period(input int ch, input int val);
    period_ms[ch*MSW +: MSW] = MSW'(val);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    m_tick = 1'b0;
    if (!reset) begin
      en_cycles = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_run[c] = 0; m_done[c] = 0; m_exp[c] = 0; m_per[c] = 0; m_rem[c] = 0;
      end
      return;
    end
    if (enable) begin
      m_tick = ((en_cycles % CPM) == CPM - 1);
      en_cycles++;
    end
    for (int c = 0; c < N_CH; c++) begin
      m_exp[c] = 0;
      if (stop[c]) begin
        m_run[c] = 0; m_done[c] = 0; m_rem[c] = 0;
      end else if (start[c] && per_of(c) != 0) begin
        m_run[c] = 1; m_done[c] = 0; m_rem[c] = per_of(c); m_per[c] = periodic[c];
      end else if (m_run[c] && m_tick) begin
        if (m_rem[c] > 1) m_rem[c]--;
        else begin
          m_exp[c] = 1;
          if (m_per[c] && per_of(c) != 0) m_rem[c] = per_of(c);
          else begin
            m_run[c] = 0; m_done[c] = 1; m_rem[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [N_CH-1:0]     e_exp, e_run, e_done;
    logic [N_CH*MSW-1:0] e_rem;
    model_update();
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) begin
      e_exp[c]  = m_exp[c];
      e_run[c]  = m_run[c];
      e_done[c] = m_done[c];
      e_rem[c*MSW +: MSW] = MSW'(m_rem[c]);
    end
    check("model_expired",   32'(expired),  32'(e_exp));
    check("model_running",   32'(running),  32'(e_run));
    check("model_done",      32'(done),     32'(e_done));
    check("model_remaining", remaining_ms,  e_rem);
  endtask

  initial begin
    int pulses, ticks, guard, bad, seen;
    reset = 1'b0; enable = 1'b1; start = '0; stop = '0; periodic = '0; period_ms = '0;
    step();
    step();
    check("reset_running", 32'(running), 32'd0);
    check("reset_remaining", remaining_ms, 32'd0);

    // One-shot ch0, period 3
    reset = 1'b1;
    set_period(0, 3); periodic[0] = 1'b0; start[0] = 1'b1;
    step();
    start = '0;
    pulses = 0;
    repeat (16) begin
      step();
      if (expired[0]) pulses++;
    end
    check("oneshot_pulses", 32'(pulses), 32'd1);
    check("oneshot_done", 32'(done[0]), 32'd1);
    check("oneshot_running", 32'(running[0]), 32'd0);
    check("oneshot_remaining", 32'(rem_of(0)), 32'd0);

    // Periodic ch1, period 2, for 10 ticks
    set_period(1, 2); periodic[1] = 1'b1; start[1] = 1'b1;
    step();
    start = '0;
    ticks = 0; pulses = 0; bad = 0; guard = 0;
    while (ticks < 10 && guard < 100) begin
      step();
      guard++;
      if (m_tick) ticks++;
      if (expired[1]) begin
        pulses++;
        if (ticks % 2 != 0) bad++;
      end
      if (!running[1]) bad++;
    end
    check("periodic_ticks", 32'(ticks), 32'd10);
    check("periodic_pulses", 32'(pulses), 32'd5);
    check("periodic_phase_run", 32'(bad), 32'd0);
    stop[1] = 1'b1;
    step();
    stop = '0;

    // Enable hold on ch2
    set_period(2, 5); periodic[2] = 1'b0; start[2] = 1'b1;
    step();
    start = '0;
    ticks = 0; guard = 0;
    while (ticks < 2 && guard < 50) begin
      step();
      guard++;
      if (m_tick) ticks++;
    end
    check("hold_before", 32'(rem_of(2)), 32'd3);
    enable = 1'b0; bad = 0;
    repeat (20) begin
      step();
      if (rem_of(2) != 3) bad++;
    end
    check("hold_frozen", 32'(bad), 32'd0);
    enable = 1'b1; ticks = 0; guard = 0;
    while (ticks < 1 && guard < 50) begin
      step();
      guard++;
      if (m_tick) ticks++;
    end
    check("hold_resume", 32'(rem_of(2)), 32'd2);
    stop[2] = 1'b1;
    step();
    stop = '0;

    // ch3: start+stop together, then zero-period start while running
    set_period(3, 5); start[3] = 1'b1; stop[3] = 1'b1;
    step();
    start = '0; stop = '0;
    check("startstop_running", 32'(running[3]), 32'd0);
    check("startstop_remaining", 32'(rem_of(3)), 32'd0);
    check("startstop_expired", 32'(expired[3]), 32'd0);
    enable = 1'b0; start[3] = 1'b1;
    step();
    set_period(3, 0);
    step();
    start = '0;
    check("zero_period_running", 32'(running[3]), 32'd1);
    check("zero_period_remaining", 32'(rem_of(3)), 32'd5);
    check("zero_period_expired", 32'(expired[3]), 32'd0);
    enable = 1'b1;

    // Reset mid-count, then a full-period count
    for (int c = 0; c < N_CH; c++) set_period(c, 6);
    periodic = 4'b1010; start = '1;
    step();
    start = '0;
    repeat (9) step();
    reset = 1'b0;
    step();
    check("midreset_expired", 32'(expired), 32'd0);
    check("midreset_running", 32'(running), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_remaining", remaining_ms, 32'd0);
    reset = 1'b1; periodic = '0;
    set_period(0, 3); start[0] = 1'b1;
    step();
    start = '0;
    ticks = 0; seen = 0; guard = 0;
    while (!seen && guard < 60) begin
      step();
      guard++;
      if (m_tick) ticks++;
      if (expired[0]) seen = 1;
    end
    check("after_reset_seen", 32'(seen), 32'd1);
    check("after_reset_ticks", 32'(ticks), 32'd3);

    // Restart ch0 at remaining 1
    set_period(0, 4); start[0] = 1'b1;
    step();
    start = '0; guard = 0;
    while (rem_of(0) != 1 && guard < 40) begin
      step();
      guard++;
    end
    check("restart_reach1", 32'(rem_of(0)), 32'd1);
    start[0] = 1'b1;
    step();
    start = '0;
    check("restart_no_expiry", 32'(expired[0]), 32'd0);
    check("restart_reload", 32'(rem_of(0)), 32'd4);
    ticks = 0; seen = 0; guard = 0;
    while (!seen && guard < 60) begin
      step();
      guard++;
      if (m_tick) ticks++;
      if (expired[0]) seen = 1;
    end
    check("restart_seen", 32'(seen), 32'd1);
    check("restart_ticks", 32'(ticks), 32'd4);

    // Random traffic against the model
    repeat (400) begin
      for (int c = 0; c < N_CH; c++) begin
        start[c]    = ($urandom % 10) == 0;
        stop[c]     = ($urandom % 40) == 0;
        periodic[c] = $urandom % 2;
        set_period(c, int'($urandom % 6));
      end
      enable = ($urandom % 8) != 0;
      reset  = ($urandom % 150) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
